// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed program from a host and writes it into IMEM
module prog_loader #(
    parameter logic [7:0] HALT_WORD = 8'hF0,
    parameter int         DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       imem_we,
    output logic [3:0] imem_waddr,
    output logic [7:0] imem_wdata,
    output logic       cpu_rst_n,
    output logic       load_done,
    output logic       load_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] PAD   = 3'd4;
    localparam logic [2:0] RUN   = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;
    localparam logic [4:0] fullLen  = 5'(DEPTH);
    localparam logic [4:0] lastAddr = 5'(DEPTH - 1);

    logic [2:0] state, nextState;
    logic [4:0] cnt, len;
    logic [7:0] sum;
    logic       accept;

    assign in_ready = (state == HDR) || (state == LOAD) || (state == CHECK);
    assign accept   = in_valid && in_ready;

    // next-state decode; bytes only move the FSM when actually accepted
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? HDR : IDLE;
            HDR:     if (accept) nextState = (in_data != 8'd0 && in_data <= 8'(DEPTH)) ? LOAD : ERROR;
            LOAD:    if (accept && cnt + 5'd1 == len) nextState = CHECK;
            CHECK:   if (accept) nextState = (in_data != sum) ? ERROR : (len == fullLen) ? RUN : PAD;
            PAD:     nextState = (cnt == lastAddr) ? RUN : PAD;
            RUN:     nextState = start ? HDR : RUN;
            ERROR:   nextState = start ? HDR : ERROR;
            default: nextState = IDLE;
        endcase
    end

    // state, counters, registered IMEM write port and status outputs decoded from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            sum        <= 8'd0;
            len        <= 5'd0;
            imem_we    <= 1'b0;
            imem_waddr <= 4'd0;
            imem_wdata <= 8'd0;
            cpu_rst_n  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= nextState;
            imem_we   <= 1'b0;
            cpu_rst_n <= nextState == RUN;
            load_done <= nextState == RUN;
            load_err  <= nextState == ERROR;
            if (state == HDR && accept) begin
                len <= in_data[4:0];
                cnt <= 5'd0;
                sum <= 8'd0;
            end
            if (state == LOAD && accept) begin
                imem_we    <= 1'b1;
                imem_waddr <= cnt[3:0];
                imem_wdata <= in_data;
                sum        <= sum + in_data;
                cnt        <= cnt + 5'd1;
            end
            if (state == PAD) begin
                imem_we    <= 1'b1;
                imem_waddr <= cnt[3:0];
                imem_wdata <= HALT_WORD;
                cnt        <= cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized program loads checked against a list-based reference model
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, imem_we, cpu_rst_n, load_done, load_err;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;

    int compared = 0;
    int failed = 0;
    int cyc = 0;
    logic [3:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    logic [7:0] payload[$];

    prog_loader #(.HALT_WORD(8'hF0), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_waddr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearWrites();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                start = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic runLoad(input logic [7:0] len, input logic [7:0] chk, input bit gaps, input bit padValid, input string tag);
        logic [3:0] ea[$];
        logic [7:0] ed[$];
        logic [7:0] s;
        bit expRun, lenOk;
        int padN, n;
        s = 8'd0;
        expRun = 0;
        padN = 0;
        lenOk = (len >= 8'd1 && len <= 8'd16);
        if (lenOk) begin
            foreach (payload[i]) begin
                ea.push_back(4'(i));
                ed.push_back(payload[i]);
                s = s + payload[i];
            end
            if (s == chk) begin
                expRun = 1;
                for (int a = int'(len); a < 16; a++) begin
                    ea.push_back(4'(a));
                    ed.push_back(8'hF0);
                end
                padN = 16 - int'(len);
            end
        end
        clearWrites();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_hdr_ready"}, in_ready, 1);
        check({tag, "_hdr_err"}, load_err, 0);
        check({tag, "_hdr_done"}, load_done, 0);
        check({tag, "_hdr_cpurst"}, cpu_rst_n, 0);
        sendByte(len, gaps);
        if (lenOk) begin
            foreach (payload[i]) sendByte(payload[i], gaps);
            sendByte(chk, gaps);
        end
        if (padValid) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
        end
        n = 0;
        while (!(load_done || load_err) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_end_timeout"}, n < 60, 1);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_nwrites"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check({tag, "_waddr"}, wa[i], ea[i]);
            check({tag, "_wdata"}, wd[i], ed[i]);
        end
        if (padN > 0 && wa.size() == ea.size())
            check({tag, "_pad_cycles"}, wc[wc.size() - 1] - wc[wc.size() - padN], padN - 1);
        check({tag, "_done"}, load_done, expRun);
        check({tag, "_err"}, load_err, !expRun);
        check({tag, "_cpurst"}, cpu_rst_n, expRun);
        check({tag, "_ready_idle"}, in_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s, l;
        rst_n = 1'b0;
        in_valid = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpurst", cpu_rst_n, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", in_ready, 0);

        payload = '{8'h12, 8'h34, 8'h56};
        runLoad(8'h03, 8'h9C, 0, 0, "nominal");

        payload.delete();
        for (int i = 0; i < 16; i++) payload.push_back(8'(i));
        runLoad(8'h10, 8'h78, 0, 0, "full");

        payload = '{8'h01, 8'h02};
        runLoad(8'h02, 8'h04, 0, 0, "badsum");

        payload.delete();
        runLoad(8'h00, 8'h00, 0, 0, "len00");
        runLoad(8'h11, 8'h00, 0, 0, "len11");

        payload = '{8'h12, 8'h34, 8'h56};
        runLoad(8'h03, 8'h9C, 1, 1, "backpressure");

        payload = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        clearWrites();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sendByte(8'h05, 0);
        sendByte(payload[0], 0);
        sendByte(payload[1], 0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = payload[2];
        @(posedge clk);
        #1;
        check("midrst_we", imem_we, 0);
        check("midrst_waddr", imem_waddr, 0);
        check("midrst_wdata", imem_wdata, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_flags", {cpu_rst_n, load_done, load_err}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midrst_nwrites", wa.size(), 2);
        check("midrst_addr1", wa.size() == 2 ? wa[1] : 4'hX, 4'd1);
        check("midrst_ready_after", in_ready, 0);
        payload = '{8'h12, 8'h34, 8'h56};
        runLoad(8'h03, 8'h9C, 0, 0, "after_rst");

        for (int t = 0; t < 8; t++) begin
            l = 8'($urandom_range(1, 16));
            payload.delete();
            s = 8'd0;
            for (int i = 0; i < int'(l); i++) begin
                payload.push_back(8'($urandom));
                s = s + payload[i];
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            runLoad(l, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
        payload.delete();
        runLoad(8'($urandom_range(17, 255)), 8'h00, 0, 0, "random_badlen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
